// File: rtl/adc_pkg.sv
// Shared constants and FSM encoding for the ADC sample reader.
package adc_pkg;

    localparam int unsigned CHANNEL_DATA_WIDTH = 18;
    localparam int unsigned ADC_FRAME_WIDTH    = 2 * CHANNEL_DATA_WIDTH;
    localparam int unsigned SPI_CLK_DIV        = 2;
    localparam int unsigned STATE_WIDTH        = 5;

    typedef enum logic [STATE_WIDTH-1:0] {
        StIdle     = 5'b00001,
        StCnv      = 5'b00010,
        StWaitBusy = 5'b00100,
        StShift    = 5'b01000,
        StDone     = 5'b10000
    } adc_state_e;

endpackage

// File: rtl/adc_spi_rx.sv
// Receive-only SPI shift engine: clocks in FRAME_WIDTH bits MSB first, sck idles low.
module adc_spi_rx #(
    parameter int unsigned SPI_CLK_DIV = adc_pkg::SPI_CLK_DIV,
    parameter int unsigned FRAME_WIDTH = adc_pkg::ADC_FRAME_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   miso,
    output logic                   sck,
    output logic [FRAME_WIDTH-1:0] frame,
    output logic                   done
);

    localparam int unsigned DIV_W = (SPI_CLK_DIV > 1) ? $clog2(SPI_CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(FRAME_WIDTH + 1);

    logic                   r_active;
    logic                   r_sck;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [FRAME_WIDTH-1:0] r_shift;

    logic w_div_end;
    logic w_fall;

    assign w_div_end = (r_div_cnt == DIV_W'(SPI_CLK_DIV - 1));
    assign w_fall    = r_active & r_sck & w_div_end;
    assign done      = w_fall & (r_bit_cnt == BIT_W'(FRAME_WIDTH - 1));
    // Includes the bit sampled on this edge, so it is complete whenever done is high.
    assign frame     = {r_shift[FRAME_WIDTH-2:0], miso};
    assign sck       = r_sck;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active  <= 1'b0;
            r_sck     <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (start) begin
            r_active  <= 1'b1;
            r_sck     <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (r_active) begin
            if (w_div_end) begin
                r_div_cnt <= '0;
                r_sck     <= ~r_sck;
                if (r_sck) begin
                    r_shift   <= frame;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (done) begin
                        r_active <= 1'b0;
                    end
                end
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_sample_reader.sv
// ADC front-end: CNV pulse, wait for synchronised BUSY, read a two-channel SPI frame.
module adc_sample_reader #(
    parameter int unsigned CHANNEL_DATA_WIDTH = adc_pkg::CHANNEL_DATA_WIDTH,
    parameter int unsigned SPI_CLK_DIV        = adc_pkg::SPI_CLK_DIV,
    parameter int unsigned CNV_HIGH_CYCLES    = 4,
    parameter int unsigned BUSY_TIMEOUT       = 200,
    parameter int unsigned TIMEOUT_WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_req,
    output logic                          adc_cnv,
    input  logic                          adc_busy,
    output logic                          sck,
    input  logic                          miso,
    output logic [CHANNEL_DATA_WIDTH-1:0] ch1_data,
    output logic [CHANNEL_DATA_WIDTH-1:0] ch2_data,
    output logic                          sample_valid,
    output logic                          busy,
    output logic                          overrun,
    output logic                          timeout
);

    import adc_pkg::*;

    localparam int unsigned FRAME_W = 2 * CHANNEL_DATA_WIDTH;
    localparam int unsigned CNV_W   = $clog2(CNV_HIGH_CYCLES + 1);

    adc_state_e                  r_state;
    adc_state_e                  w_state_next;
    logic                        r_busy_s1;
    logic                        r_busy_s2;
    logic                        r_seen_high;
    logic [CNV_W-1:0]            r_cnv_cnt;
    logic [TIMEOUT_WIDTH-1:0]    r_to_cnt;
    logic                        r_cnv;
    logic                        r_overrun;
    logic                        r_timeout;
    logic [CHANNEL_DATA_WIDTH-1:0] r_ch1;
    logic [CHANNEL_DATA_WIDTH-1:0] r_ch2;

    logic               w_complete;
    logic               w_expired;
    logic               w_spi_start;
    logic               w_spi_done;
    logic [FRAME_W-1:0] w_frame;

    assign w_complete = r_seen_high & ~r_busy_s2;
    assign w_expired  = (r_to_cnt == TIMEOUT_WIDTH'(BUSY_TIMEOUT - 1));

    always_comb begin
        w_state_next = r_state;
        w_spi_start  = 1'b0;
        unique case (r_state)
            StIdle:     if (sample_req) w_state_next = StCnv;
            StCnv:      if (r_cnv_cnt == CNV_W'(CNV_HIGH_CYCLES - 1)) w_state_next = StWaitBusy;
            StWaitBusy: begin
                // Completion wins over expiry on the same cycle.
                if (w_complete) begin
                    w_state_next = StShift;
                    w_spi_start  = 1'b1;
                end else if (w_expired) begin
                    w_state_next = StIdle;
                end
            end
            StShift:    if (w_spi_done) w_state_next = StDone;
            StDone:     w_state_next = StIdle;
            default:    w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_busy_s1   <= 1'b0;
            r_busy_s2   <= 1'b0;
            r_seen_high <= 1'b0;
            r_cnv_cnt   <= '0;
            r_to_cnt    <= '0;
            r_cnv       <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
            r_ch1       <= '0;
            r_ch2       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_busy_s1   <= adc_busy;
            r_busy_s2   <= r_busy_s1;
            r_seen_high <= (r_state == StWaitBusy) & (r_seen_high | r_busy_s2);
            r_cnv_cnt   <= (r_state == StCnv) ? r_cnv_cnt + 1'b1 : '0;
            r_to_cnt    <= (r_state == StWaitBusy) ? r_to_cnt + 1'b1 : '0;
            r_cnv       <= (w_state_next == StCnv);
            r_overrun   <= sample_req & (r_state != StIdle);
            r_timeout   <= (r_state == StWaitBusy) & ~w_complete & w_expired;
            if ((r_state == StShift) && w_spi_done) begin
                r_ch1 <= w_frame[FRAME_W-1:CHANNEL_DATA_WIDTH];
                r_ch2 <= w_frame[CHANNEL_DATA_WIDTH-1:0];
            end
        end
    end

    adc_spi_rx #(
        .SPI_CLK_DIV (SPI_CLK_DIV),
        .FRAME_WIDTH (FRAME_W)
    ) u_spi_rx (
        .clk   (clk),
        .rst   (rst),
        .start (w_spi_start),
        .miso  (miso),
        .sck   (sck),
        .frame (w_frame),
        .done  (w_spi_done)
    );

    assign adc_cnv      = r_cnv;
    assign ch1_data     = r_ch1;
    assign ch2_data     = r_ch2;
    assign sample_valid = (r_state == StDone);
    assign busy         = (r_state != StIdle);
    assign overrun      = r_overrun;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_adc_sample_reader.sv
// Scoreboard bench for adc_sample_reader with a behavioural ADC (BUSY + SPI slave).
module tb_adc_sample_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_req = 1'b0;
    logic        adc_busy = 1'b0;
    logic        miso;
    logic        adc_cnv, sck, sample_valid, busy, overrun, timeout;
    logic [17:0] ch1_data, ch2_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [35:0] adc_word = '0;
    int          bit_idx = 0;
    int          busy_hold = 40;    // 0: ADC never raises BUSY
    logic        prev_valid = 1'b0;
    int          cnv_run = 0;

    typedef struct {
        logic [17:0] ch1;
        logic [17:0] ch2;
        int          at;
    } exp_t;

    exp_t q_valid[$];
    int   q_ovr[$];
    int   q_tmo[$];

    adc_sample_reader dut (
        .clk          (clk),
        .rst          (rst),
        .sample_req   (sample_req),
        .adc_cnv      (adc_cnv),
        .adc_busy     (adc_busy),
        .sck          (sck),
        .miso         (miso),
        .ch1_data     (ch1_data),
        .ch2_data     (ch2_data),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC BUSY: rises 3 cycles after CNV falls, held busy_hold cycles.
    initial begin
        forever begin
            @(negedge adc_cnv);
            if (busy_hold != 0) begin
                repeat (3) @(posedge clk);
                #1 adc_busy = 1'b1;
                repeat (busy_hold) @(posedge clk);
                #1 adc_busy = 1'b0;
            end
        end
    end

    // SPI slave: bit_idx counts sck falls since the last CNV.
    initial begin
        forever begin
            @(posedge adc_cnv or negedge sck);
            if (adc_cnv) bit_idx = 0;
            else bit_idx = bit_idx + 1;
        end
    end
    always_comb miso = (bit_idx < 36) ? adc_word[6'(35 - bit_idx)] : 1'b0;

    // Monitor: pops expectations whenever the DUT strobes an output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_valid) check("busy_after_valid", 64'(busy), 64'd0);
            prev_valid = sample_valid;
            if (adc_cnv) begin
                cnv_run++;
            end else if (cnv_run != 0) begin
                check("cnv_width", 64'(cnv_run), 64'd4);
                cnv_run = 0;
            end
            if (sample_valid) begin
                if (q_valid.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: got strobe at cycle %0d expected none", cyc);
                end else begin
                    e = q_valid.pop_front();
                    check("ch1_data", 64'(ch1_data), 64'(e.ch1));
                    check("ch2_data", 64'(ch2_data), 64'(e.ch2));
                    check("valid_cycle", 64'(cyc), 64'(e.at));
                    check("sck_falls", 64'(bit_idx), 64'd36);
                end
            end
            if (overrun) begin
                if (q_ovr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_overrun: got pulse at cycle %0d expected none", cyc);
                end else begin
                    check("overrun_cycle", 64'(cyc), 64'(q_ovr.pop_front()));
                end
            end
            if (timeout) begin
                if (q_tmo.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_timeout: got pulse at cycle %0d expected none", cyc);
                end else begin
                    check("timeout_cycle", 64'(cyc), 64'(q_tmo.pop_front()));
                    check("timeout_no_sck", 64'(bit_idx), 64'd0);
                end
            end
        end
    end

    task automatic pulse_req(output int p);
        @(posedge clk); #1;
        sample_req = 1'b1;
        p = cyc;
        @(posedge clk); #1;
        sample_req = 1'b0;
    endtask

    task automatic issue(input logic [35:0] word, output int p);
        adc_word = word;
        pulse_req(p);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy || q_valid.size() != 0 || q_ovr.size() != 0 || q_tmo.size() != 0)
               && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: got still pending after %0d cycles expected idle", name, budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Valid lands at p + 149 + W. With a 40-cycle BUSY starting 3 cycles after CNV,
    // W = 3 + 40 + 2 (sync) + 1 = 46 WAIT_BUSY cycles.
    initial begin
        int p, p2, n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnv", 64'(adc_cnv), 64'd0);
        check("rst_sck", 64'(sck), 64'd0);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ch1", 64'(ch1_data), 64'd0);
        check("rst_ch2", 64'(ch2_data), 64'd0);
        @(negedge clk) rst = 1'b1;

        // Nominal: low 18 bits of 36'h2_AAAA_5555 are 18'h25555.
        busy_hold = 40;
        issue(36'h2_AAAA_5555, p);
        q_valid.push_back('{18'h0AAAA, 18'h25555, p + 149 + 46});
        wait_idle(400, "nominal");

        // Overrun: second request mid-transaction is ignored.
        issue(36'hC_0000_0003, p);
        q_valid.push_back('{18'h30000, 18'h00003, p + 149 + 46});
        repeat (17) @(posedge clk);
        pulse_req(p2);
        q_ovr.push_back(p2 + 1);
        wait_idle(400, "overrun");

        // Timeout: BUSY never rises; data keeps the previous frame.
        busy_hold = 0;
        issue(36'h5_5555_5555, p);
        q_tmo.push_back(p + 5 + 200);
        wait_idle(400, "timeout");
        check("hold_ch1", 64'(ch1_data), 64'h30000);
        check("hold_ch2", 64'(ch2_data), 64'h00003);

        // Boundary: synced BUSY falls on the last count; W = 200.
        busy_hold = 194;
        issue(36'hF_FFFF_FFFF, p);
        q_valid.push_back('{18'h3FFFF, 18'h3FFFF, p + 149 + 200});
        wait_idle(600, "boundary");

        // Asynchronous reset while sck is high during bit 10.
        busy_hold = 40;
        issue(36'hA_5A5A_5A5A, p);
        n = 0;
        while (!(bit_idx == 10 && sck) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_bit10", 64'(n < 400), 64'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_sck", 64'(sck), 64'd0);
        check("mid_rst_cnv", 64'(adc_cnv), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(sample_valid), 64'd0);
        check("mid_rst_ch1", 64'(ch1_data), 64'd0);
        check("mid_rst_ch2", 64'(ch2_data), 64'd0);
        check("mid_rst_flags", 64'({overrun, timeout}), 64'd0);
        @(negedge clk) rst = 1'b1;
        issue(36'h0_0001_0001, p);
        q_valid.push_back('{18'h00000, 18'h10001, p + 149 + 46});
        wait_idle(400, "after_reset");

        // Back-to-back: second request on the first IDLE cycle after valid.
        issue(36'h0_0003_FFFF, p);
        q_valid.push_back('{18'h00000, 18'h3FFFF, p + 149 + 46});
        n = 0;
        while (!sample_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_first_seen", 64'(n < 400), 64'd1);
        issue(36'h8_0000_0000, p2);
        q_valid.push_back('{18'h20000, 18'h00000, p2 + 149 + 46});
        wait_idle(400, "back_to_back");

        check("queues_drained", 64'(q_valid.size() + q_ovr.size() + q_tmo.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule
